// File: rtl/output_pack_reg.sv
// Packs 8/16/32-bit result elements LSB-first into 32-bit buffer words; a word appears one clock after its completing beat.
// A single output register holds the word; in_ready drops while it is full and out_ready is low.
module output_pack_reg #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       bitwidth,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] word_count
);

  localparam logic [1:0] MODE_32 = 2'b00;
  localparam logic [1:0] MODE_16 = 2'b01;
  localparam logic [1:0] MODE_8  = 2'b10;

  logic [1:0]  mode_q;
  logic [1:0]  lane_mode;
  logic [31:0] asm_q;
  logic [31:0] lane_bits;
  logic [31:0] merged;
  logic        accept;
  logic        last_lane;
  logic        emit;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // The mode of a word is taken from bitwidth on its first lane only.
  always_comb begin
    lane_mode = mode_q;
    if (phase == 2'd0) begin
      lane_mode = bitwidth[1] ? MODE_8 : bitwidth;
    end
  end

  always_comb begin
    lane_bits = in_data;
    last_lane = 1'b1;
    case (lane_mode)
      MODE_16: begin
        lane_bits = {16'h0000, in_data[15:0]} << {phase[0], 4'b0000};
        last_lane = (phase == 2'd1);
      end
      MODE_8: begin
        lane_bits = {24'h000000, in_data[7:0]} << {phase, 3'b000};
        last_lane = (phase == 2'd3);
      end
      default: begin
        lane_bits = in_data;
        last_lane = 1'b1;
      end
    endcase
  end

  assign merged = accept ? (asm_q | lane_bits) : asm_q;
  assign emit   = (accept && last_lane) ||
                  (flush && in_ready && ((phase != 2'd0) || accept));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q     <= MODE_32;
      asm_q      <= '0;
      phase      <= 2'd0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      word_count <= '0;
    end else begin
      if (accept && (phase == 2'd0)) begin
        mode_q <= lane_mode;
      end
      if (emit) begin
        out_data   <= merged;
        out_valid  <= 1'b1;
        asm_q      <= '0;
        phase      <= 2'd0;
        word_count <= word_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        if (out_ready) begin
          out_valid <= 1'b0;
        end
        if (accept) begin
          asm_q <= merged;
          phase <= phase + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_output_pack_reg.sv
// Randomized and directed bench for output_pack_reg against a transaction-level packing model.
module tb_output_pack_reg;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  bitwidth = 2'b00;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [1:0]  phase;
  logic [15:0] word_count;

  logic        in_ready2, out_valid2;
  logic [31:0] out_data2;
  logic [1:0]  phase2;
  logic [1:0]  word_count2;

  int n_checks = 0;
  int n_err    = 0;

  // reference model state: elements packed into the current word, pending output word
  int          m_nfill;
  int          m_w;
  logic [31:0] m_word;
  logic        m_ov;
  logic [31:0] m_od;
  int          m_cnt;

  output_pack_reg #(.CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .bitwidth(bitwidth), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .phase(phase), .word_count(word_count)
  );

  output_pack_reg #(.CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .bitwidth(bitwidth), .in_valid(in_valid),
    .in_ready(in_ready2), .in_data(in_data), .flush(flush), .out_valid(out_valid2),
    .out_ready(out_ready), .out_data(out_data2), .phase(phase2), .word_count(word_count2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_nfill = 0;
    m_w     = 32;
    m_word  = '0;
    m_ov    = 1'b0;
    m_od    = '0;
    m_cnt   = 0;
  endtask

  // Called at a negedge with inputs already applied; returns at the following negedge.
  task automatic step();
    logic   rdy, acc;
    longint elem;
    #1;
    rdy = !m_ov || out_ready;
    acc = in_valid && rdy;
    chk("in_ready", {31'b0, in_ready}, {31'b0, rdy});
    if (m_ov && out_ready) m_ov = 1'b0;
    if (acc) begin
      if (m_nfill == 0) m_w = (bitwidth == 2'b00) ? 32 : (bitwidth == 2'b01) ? 16 : 8;
      elem   = longint'(in_data) & ((64'd1 << m_w) - 64'd1);
      m_word = m_word | 32'(elem << (m_nfill * m_w));
      m_nfill++;
    end
    if (rdy && ((acc && (m_nfill * m_w == 32)) || (flush && m_nfill > 0))) begin
      m_ov    = 1'b1;
      m_od    = m_word;
      m_word  = '0;
      m_nfill = 0;
      m_cnt   = (m_cnt + 1) % 65536;
    end
    @(posedge clk);
    @(negedge clk);
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_ov});
    if (m_ov) chk("out_data", out_data, m_od);
    chk("phase", {30'b0, phase}, 32'(m_nfill));
    chk("word_count", {16'b0, word_count}, 32'(m_cnt));
    chk("word_count_w2", {30'b0, word_count2}, 32'(m_cnt % 4));
  endtask

  task automatic beat(input logic [1:0] bw, input logic [31:0] d, input logic v,
                      input logic ordy, input logic fl);
    bitwidth  = bw;
    in_data   = d;
    in_valid  = v;
    out_ready = ordy;
    flush     = fl;
    step();
  endtask

  // Asserts reset mid-cycle and checks the asynchronous clear before any clock edge.
  task automatic do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    reset_n   = 1'b0;
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_phase", {30'b0, phase}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_word_count", {16'b0, word_count}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // 8-bit packing
    beat(2'b10, 32'hFFFF_FF11, 1, 1, 0);
    beat(2'b10, 32'h22, 1, 1, 0);
    beat(2'b10, 32'h33, 1, 1, 0);
    beat(2'b10, 32'h44, 1, 1, 0);
    chk("d8_data", out_data, 32'h4433_2211);
    chk("d8_valid", {31'b0, out_valid}, 32'd1);
    chk("d8_count", {16'b0, word_count}, 32'd1);
    beat(2'b10, 32'h0, 0, 1, 0);

    // 16-bit word held under backpressure
    beat(2'b01, 32'h1234_AAAA, 1, 1, 0);
    beat(2'b01, 32'hBBBB, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      beat(2'b01, 32'h5555, 1, 0, 0);
      chk("d16_hold", out_data, 32'hBBBB_AAAA);
      chk("d16_inrdy", {31'b0, in_ready}, 32'd0);
    end
    beat(2'b01, 32'h0, 0, 1, 0);
    chk("d16_drained", {31'b0, out_valid}, 32'd0);
    chk("d16_count", {16'b0, word_count}, 32'd2);

    // partial word flushed
    beat(2'b10, 32'h01, 1, 1, 0);
    beat(2'b10, 32'h02, 1, 1, 0);
    beat(2'b10, 32'h0, 0, 1, 1);
    chk("flush_data", out_data, 32'h0000_0201);
    chk("flush_phase", {30'b0, phase}, 32'd0);
    beat(2'b10, 32'h0, 0, 1, 1);
    chk("flush_idle_noeffect", {31'b0, out_valid}, 32'd0);

    // mode switch mid-word is ignored until the word completes
    beat(2'b10, 32'h11, 1, 1, 0);
    beat(2'b01, 32'h22, 1, 1, 0);
    beat(2'b01, 32'h33, 1, 1, 0);
    beat(2'b01, 32'h44, 1, 1, 0);
    chk("switch_8", out_data, 32'h4433_2211);
    beat(2'b01, 32'h1234, 1, 1, 0);
    beat(2'b01, 32'h5678, 1, 1, 0);
    chk("switch_16", out_data, 32'h5678_1234);

    // 32-bit streaming, one word per cycle, with narrow counter wrap
    do_reset();
    for (int i = 0; i < 5; i++) beat(2'b00, 32'hC0DE_0000 + i, 1, 1, 0);
    chk("s32_count", {16'b0, word_count}, 32'd5);
    chk("s32_count_w2", {30'b0, word_count2}, 32'd1);
    chk("s32_last", out_data, 32'hC0DE_0004);
    beat(2'b00, 32'h0, 0, 1, 0);

    // reset mid-word discards partial lanes
    beat(2'b10, 32'hAA, 1, 1, 0);
    beat(2'b10, 32'hBB, 1, 1, 0);
    do_reset();
    for (int i = 5; i <= 8; i++) beat(2'b10, 32'(i), 1, 1, 0);
    chk("rst_mid_word", out_data, 32'h0807_0605);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) bitwidth = 2'($urandom_range(0, 3));
      in_data   = $urandom;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 11) == 0);
      step();
      if (i == 1500) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
